conv77_pim_sched: RTL and testbench

Sequencing controller for the 6-bit bit-sliced conv7x7 PIM datapath. On start it sweeps PIM row addresses 0..last and pulses the compute enable once per address. It captures the four 6-bit slice results (HH, HL, LH, LL) after a fixed array latency and recombines them with the correct binary weights. Each recombined value is presented on a valid/ready output stream, tagged with its address.

---
 rtl/conv77_pim_sched.sv | 145 ++++++++++++++
 tb/tb_conv77_pim_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv77_pim_sched.sv
// Sequencer for the bit-sliced conv7x7 PIM array: sweeps row addresses, captures the
// four slice results after the array latency, recombines them and streams them out.
module conv77_pim_sched #(
    parameter int ADDR_W  = 5,
    parameter int SLICE_W = 6,
    parameter int OUT_W   = 16,
    parameter int PIM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_last_addr,
    input  logic               abort,
    output logic [ADDR_W-1:0]  pim_addr,
    output logic               pim_en,
    input  logic [SLICE_W-1:0] pim_hh,
    input  logic [SLICE_W-1:0] pim_hl,
    input  logic [SLICE_W-1:0] pim_lh,
    input  logic [SLICE_W-1:0] pim_ll,
    output logic [OUT_W-1:0]   out_data,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_ISSUE    | pim_en pulse for the current address
    // S_WAIT     | array latency countdown, slices captured on the last count
    // S_COMBINE  | weighted recombination registered into out_data
    // S_OUTPUT   | out_valid held until downstream accepts
    // S_DONE     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam int HI_SH = SLICE_W;
    localparam int MID_SH = SLICE_W / 2;
    localparam logic [3:0] LAT_INIT = 4'(PIM_LAT);

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  cur, last;
    logic [3:0]         wait_cnt;
    logic [SLICE_W-1:0] hh_q, hl_q, lh_q, ll_q;
    logic [OUT_W-1:0]   combined;
    logic               take_start, load_slices, advance;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        take_start  = 1'b0;
        load_slices = 1'b0;
        advance     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    take_start = 1'b1;
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    load_slices = 1'b1;
                    state_nxt   = S_COMBINE;
                end
            end
            S_COMBINE: state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                if (out_ready) begin
                    if (cur == last) begin
                        state_nxt = S_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort discards whatever is in flight, including a pending output.
        if (abort && state != S_IDLE) begin
            state_nxt   = S_IDLE;
            load_slices = 1'b0;
            advance     = 1'b0;
        end
    end

    always_comb begin
        combined = (OUT_W'(hh_q) << HI_SH) + (OUT_W'(hl_q) << MID_SH)
                 + (OUT_W'(lh_q) << MID_SH) + OUT_W'(ll_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= '0;
            last     <= '0;
            wait_cnt <= '0;
            hh_q     <= '0;
            hl_q     <= '0;
            lh_q     <= '0;
            ll_q     <= '0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            if (take_start) begin
                last <= cfg_last_addr;
                cur  <= '0;
            end
            if (advance) cur <= cur + ADDR_W'(1);
            if (state == S_ISSUE)     wait_cnt <= LAT_INIT;
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (load_slices) begin
                hh_q <= pim_hh;
                hl_q <= pim_hl;
                lh_q <= pim_lh;
                ll_q <= pim_ll;
            end
            if (state == S_COMBINE) begin
                out_data <= combined;
                out_addr <= cur;
            end
        end
    end

    assign pim_addr  = cur;
    assign pim_en    = (state == S_ISSUE);
    assign out_valid = (state == S_OUTPUT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_conv77_pim_sched.sv
// Directed bench for conv77_pim_sched: single/multi sweeps, back-pressure, abort,
// ignored restart, mid-sweep reset and a full address sweep.
module tb_conv77_pim_sched;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [4:0]  cfg_last_addr;
    logic [4:0]  pim_addr, out_addr;
    logic        pim_en, out_valid, busy, done;
    logic [5:0]  pim_hh, pim_hl, pim_lh, pim_ll;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    conv77_pim_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_last_addr(cfg_last_addr), .abort(abort),
        .pim_addr(pim_addr), .pim_en(pim_en),
        .pim_hh(pim_hh), .pim_hl(pim_hl), .pim_lh(pim_lh), .pim_ll(pim_ll),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_slices(input logic [5:0] hh, hl, lh, ll);
        pim_hh = hh; pim_hl = hl; pim_lh = lh; pim_ll = ll;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; cfg_last_addr = '0;
        set_slices(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (pim_addr !== 5'd0) begin errors++; $display("FAIL reset_pim_addr got %0d exp 0", pim_addr); end
        checks++; if (pim_en !== 1'b0) begin errors++; $display("FAIL reset_pim_en got %b exp 0", pim_en); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (out_addr !== 5'd0) begin errors++; $display("FAIL reset_out_addr got %0d exp 0", out_addr); end
        checks++; if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {out_valid, busy, done}); end
    endtask

    task automatic test_single();
        set_slices(1, 2, 3, 4);
        cfg_last_addr = 5'd0; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        checks++; if ({pim_en, pim_addr, busy} !== {1'b1, 5'd0, 1'b1}) begin errors++; $display("FAIL single_issue got en=%b addr=%0d busy=%b exp 1/0/1", pim_en, pim_addr, busy); end
        tick();
        checks++; if (pim_en !== 1'b0) begin errors++; $display("FAIL single_wait_en got %b exp 0", pim_en); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
        tick();
        checks++; if ({out_valid, out_data, out_addr, done} !== {1'b1, 16'd108, 5'd0, 1'b0}) begin errors++; $display("FAIL single_out got v=%b d=%0d a=%0d done=%b exp 1/108/0/0", out_valid, out_data, out_addr, done); end
        tick();
        checks++; if ({done, out_valid, busy} !== 3'b101) begin errors++; $display("FAIL single_done got done/valid/busy=%b exp 101", {done, out_valid, busy}); end
        tick();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL single_idle got done/busy=%b exp 00", {done, busy}); end
    endtask

    task automatic test_multi();
        int n_out = 0, n_en = 0, n_done = 0, prev = 0;
        set_slices(63, 63, 63, 63);
        cfg_last_addr = 5'd3; out_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick(); start = 1'b0;
            if (pim_en) n_en++;
            if (done) n_done++;
            checks++; if (out_valid && done) begin errors++; $display("FAIL multi_valid_with_done at cycle %0d", c); end
            if (out_valid) begin
                checks++; if ({out_data, out_addr} !== {16'd5103, 5'(n_out)}) begin errors++; $display("FAIL multi_out got d=%0d a=%0d exp 5103/%0d", out_data, out_addr, n_out); end
                if (n_out > 0) begin
                    checks++; if (c - prev !== 4) begin errors++; $display("FAIL multi_spacing got %0d exp 4", c - prev); end
                end
                prev = c; n_out++;
            end
        end
        checks++; if (n_out !== 4) begin errors++; $display("FAIL multi_count got %0d exp 4", n_out); end
        checks++; if (n_en !== 4) begin errors++; $display("FAIL multi_pim_en got %0d exp 4", n_en); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL multi_done got %0d exp 1", n_done); end
    endtask

    task automatic test_stall();
        int n = 0;
        set_slices(0, 1, 0, 5);
        cfg_last_addr = 5'd3; out_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks++; if ({out_valid, out_addr} !== {1'b1, 5'd0}) begin errors++; $display("FAIL stall_first got v=%b a=%0d exp 1/0", out_valid, out_addr); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks++; if (out_addr !== 5'd1) begin errors++; $display("FAIL stall_addr got %0d exp 1", out_addr); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({out_valid, out_data, out_addr, pim_en} !== {1'b1, 16'd13, 5'd1, 1'b0}) begin errors++; $display("FAIL stall_hold got v=%b d=%0d a=%0d en=%b exp 1/13/1/0", out_valid, out_data, out_addr, pim_en); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if ({pim_en, pim_addr} !== {1'b1, 5'd2}) begin errors++; $display("FAIL stall_resume got en=%b addr=%0d exp 1/2", pim_en, pim_addr); end
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_timeout busy=%b exp 0", busy); end
    endtask

    task automatic test_abort();
        int n = 0;
        set_slices(2, 2, 2, 2);
        cfg_last_addr = 5'd7; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        while (!(pim_en && pim_addr == 5'd2) && n < 30) begin tick(); n++; end
        checks++; if ({pim_en, pim_addr} !== {1'b1, 5'd2}) begin errors++; $display("FAIL abort_reach got en=%b addr=%0d exp 1/2", pim_en, pim_addr); end
        tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        checks++; if ({busy, out_valid, pim_en} !== 3'b000) begin errors++; $display("FAIL abort_drop got busy/valid/en=%b exp 000", {busy, out_valid, pim_en}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL abort_no_done got done/busy=%b exp 00", {done, busy}); end
        end
        cfg_last_addr = 5'd1; start = 1'b1;
        tick(); start = 1'b0;
        checks++; if ({pim_en, pim_addr} !== {1'b1, 5'd0}) begin errors++; $display("FAIL abort_restart got en=%b addr=%0d exp 1/0", pim_en, pim_addr); end
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        // Abort and start together in IDLE must not launch a sweep.
        start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        checks++; if ({busy, pim_en} !== 2'b00) begin errors++; $display("FAIL abort_start_idle got busy/en=%b exp 00", {busy, pim_en}); end
    endtask

    task automatic test_restart_ignored();
        int n_out = 0, n_done = 0, last_a = 0, n = 0;
        set_slices(1, 1, 1, 1);
        cfg_last_addr = 5'd1; out_ready = 1'b1; start = 1'b1;
        tick();
        cfg_last_addr = 5'd5;
        while (busy && n < 60) begin
            if (n == 3) start = 1'b0;
            if (out_valid) begin n_out++; last_a = int'(out_addr); end
            if (done) n_done++;
            tick(); n++;
        end
        start = 1'b0;
        checks++; if (n_out !== 2) begin errors++; $display("FAIL restart_count got %0d exp 2", n_out); end
        checks++; if (last_a !== 1) begin errors++; $display("FAIL restart_last got %0d exp 1", last_a); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL restart_done got %0d exp 1", n_done); end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        set_slices(5, 4, 3, 2);
        cfg_last_addr = 5'd3; out_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks++; if (out_data !== 16'd378) begin errors++; $display("FAIL rst_mid_pre got %0d exp 378", out_data); end
        rst = 1'b1;
        tick();
        checks++; if ({pim_addr, pim_en, out_data, out_addr, out_valid, busy, done} !== 31'd0) begin errors++; $display("FAIL rst_mid_vals got addr=%0d en=%b d=%0d a=%0d v=%b busy=%b done=%b exp all 0", pim_addr, pim_en, out_data, out_addr, out_valid, busy, done); end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_done got done/busy=%b exp 00", {done, busy}); end
        end
    endtask

    task automatic test_full_sweep();
        int n_out = 0, n_done = 0, n = 0;
        set_slices(0, 0, 0, 7);
        cfg_last_addr = 5'd31; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        while (busy && n < 300) begin
            if (out_valid) begin
                checks++; if ({out_addr, out_data} !== {5'(n_out), 16'd7}) begin errors++; $display("FAIL full_out got a=%0d d=%0d exp %0d/7", out_addr, out_data, n_out); end
                n_out++;
            end
            if (done) n_done++;
            tick(); n++;
        end
        checks++; if (n_out !== 32) begin errors++; $display("FAIL full_count got %0d exp 32", n_out); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL full_done got %0d exp 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_abort();
        test_restart_ignored();
        test_rst_mid();
        test_full_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
